// File: rtl/apb4_bridge_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb4_bridge_pkg: FSM state, request and response types for the APB4 bridge. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
package apb4_bridge_pkg;

    // APB4 caps PADDR and PWDATA at 32 bits, so the latched types are sized to that.
    localparam int APB_MAX_ADDR_WIDTH = 32;
    localparam int APB_MAX_DATA_WIDTH = 32;
    localparam int APB_MAX_STRB_WIDTH = APB_MAX_DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb4_bridge_state_e;

    typedef struct packed {
        logic                          write;
        logic [APB_MAX_ADDR_WIDTH-1:0] addr;
        logic [APB_MAX_DATA_WIDTH-1:0] wdata;
        logic [APB_MAX_STRB_WIDTH-1:0] strb;
    } apb4_bridge_req_t;

    typedef struct packed {
        logic [APB_MAX_DATA_WIDTH-1:0] rdata;
        logic                          err;
    } apb4_bridge_rsp_t;

endpackage
`default_nettype wire

// File: rtl/apb4_addr_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb4_addr_decoder: maps the slave index field of an address to a one-hot   |
// | select plus a hit flag. Rev 1.0 - initial release                          |
// +----------------------------------------------------------------------------+
module apb4_addr_decoder
    import apb4_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLAVE_ADDR_LSB = 12
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  hit
);

    localparam int C_FIELD_W = ADDR_WIDTH - SLAVE_ADDR_LSB;

    logic [C_FIELD_W-1:0] w_field;

    assign w_field = addr[ADDR_WIDTH-1:SLAVE_ADDR_LSB];

    for (genvar i = 0; i < NUM_SLAVES; i++) begin : g_sel
        assign sel[i] = (w_field == C_FIELD_W'(i));
    end

    assign hit = |sel;

    // Offset bits inside a slave window play no part in the decode.
    if (SLAVE_ADDR_LSB > 0) begin : g_lsb_unused
        logic w_unused_lsbs;
        assign w_unused_lsbs = ^addr[SLAVE_ADDR_LSB-1:0];
    end

endmodule
`default_nettype wire

// File: rtl/apb4_multi_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | apb4_multi_master_bridge: valid/ready command channel to APB4 requester    |
// | with one-hot PSEL decode. Optional ACCESS timeout: APB4_BRIDGE_TIMEOUT_EN. |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module apb4_multi_master_bridge
    import apb4_bridge_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_SLAVES     = 4,
    parameter int SLAVE_ADDR_LSB = 12,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                             pclk,
    input  logic                             presetn,
    input  logic                             req_valid,
    output logic                             req_ready,
    input  logic                             req_write,
    input  logic [ADDR_WIDTH-1:0]            req_addr,
    input  logic [DATA_WIDTH-1:0]            req_wdata,
    input  logic [DATA_WIDTH/8-1:0]          req_strb,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [DATA_WIDTH-1:0]            rsp_rdata,
    output logic                             rsp_err,
    output logic [NUM_SLAVES-1:0]            psel,
    output logic                             penable,
    output logic                             pwrite,
    output logic [ADDR_WIDTH-1:0]            paddr,
    output logic [DATA_WIDTH-1:0]            pwdata,
    output logic [DATA_WIDTH/8-1:0]          pstrb,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] prdata,
    input  logic [NUM_SLAVES-1:0]            pready,
    input  logic [NUM_SLAVES-1:0]            pslverr
);

    apb4_bridge_state_e        r_state;
    apb4_bridge_state_e        w_next_state;
    apb4_bridge_req_t          r_req;
    apb4_bridge_rsp_t          r_rsp;
    logic [NUM_SLAVES-1:0]     r_sel;
    logic [NUM_SLAVES-1:0]     w_dec_sel;
    logic                      w_dec_hit;
    logic                      w_pready;
    logic                      w_pslverr;
    logic [DATA_WIDTH-1:0]     w_prdata;
    logic                      w_accept;
    logic                      w_done;
    logic                      w_timeout;

    apb4_addr_decoder #(
        .ADDR_WIDTH     (ADDR_WIDTH),
        .NUM_SLAVES     (NUM_SLAVES),
        .SLAVE_ADDR_LSB (SLAVE_ADDR_LSB)
    ) u_dec (
        .addr (req_addr),
        .sel  (w_dec_sel),
        .hit  (w_dec_hit)
    );

    // Only the selected slave's handshake and data are observed.
    assign w_pready  = |(pready & r_sel);
    assign w_pslverr = |(pslverr & r_sel);

    always_comb begin
        w_prdata = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (r_sel[i]) begin
                w_prdata = w_prdata | prdata[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    assign w_accept = (r_state == IDLE) && req_valid;
    assign w_done   = (r_state == ACCESS) && w_pready;

`ifdef APB4_BRIDGE_TIMEOUT_EN
    localparam int C_TMO_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

    logic [C_TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_tmo_cnt <= '0;
        end else if (r_state == SETUP) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == ACCESS) && !w_pready) begin
            r_tmo_cnt <= r_tmo_cnt + C_TMO_W'(1);
        end
    end

    // Abort on the edge where the count reaches the limit; a same-cycle pready wins.
    assign w_timeout = (r_state == ACCESS) && !w_pready &&
                       (r_tmo_cnt == C_TMO_W'(TIMEOUT_CYCLES - 1));
`else
    localparam int c_unused_timeout_cycles = TIMEOUT_CYCLES;

    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (req_valid) w_next_state = w_dec_hit ? SETUP : RESP;
            SETUP:   w_next_state = ACCESS;
            ACCESS:  if (w_pready || w_timeout) w_next_state = RESP;
            RESP:    if (rsp_ready) w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_req <= '0;
            r_rsp <= '0;
            r_sel <= '0;
        end else begin
            if (w_accept) begin
                r_req.write <= req_write;
                r_req.addr  <= APB_MAX_ADDR_WIDTH'(req_addr);
                r_req.wdata <= APB_MAX_DATA_WIDTH'(req_wdata);
                r_req.strb  <= APB_MAX_STRB_WIDTH'(req_write ? req_strb : '0);
                r_sel       <= w_dec_sel;
                r_rsp.rdata <= '0;
                r_rsp.err   <= !w_dec_hit;
            end
            if (w_done) begin
                r_rsp.rdata <= (r_req.write || w_pslverr) ? '0 : APB_MAX_DATA_WIDTH'(w_prdata);
                r_rsp.err   <= w_pslverr;
            end else if (w_timeout) begin
                r_rsp.rdata <= '0;
                r_rsp.err   <= 1'b1;
            end
        end
    end

    assign req_ready = (r_state == IDLE);
    assign rsp_valid = (r_state == RESP);
    assign penable   = (r_state == ACCESS);
    assign psel      = ((r_state == SETUP) || (r_state == ACCESS)) ? r_sel : '0;
    assign pwrite    = r_req.write;
    assign paddr     = r_req.addr[ADDR_WIDTH-1:0];
    assign pwdata    = r_req.wdata[DATA_WIDTH-1:0];
    assign pstrb     = r_req.strb[DATA_WIDTH/8-1:0];
    assign rsp_rdata = r_rsp.rdata[DATA_WIDTH-1:0];
    assign rsp_err   = r_rsp.err;

endmodule
`default_nettype wire

// File: tb/tb_apb4_multi_master_bridge.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_apb4_multi_master_bridge: directed plus randomized transfers against a  |
// | transaction-level expectation model. Rev 1.0 - initial release             |
// +----------------------------------------------------------------------------+
module tb_apb4_multi_master_bridge;

    localparam int NS  = 4;
    localparam int DW  = 32;
    localparam int TMO = 16;
`ifdef APB4_BRIDGE_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           pclk = 1'b0;
    logic           presetn;
    logic           req_valid, req_ready, req_write;
    logic [31:0]    req_addr, req_wdata;
    logic [3:0]     req_strb;
    logic           rsp_valid, rsp_ready, rsp_err;
    logic [31:0]    rsp_rdata;
    logic [NS-1:0]  psel;
    logic           penable, pwrite;
    logic [31:0]    paddr, pwdata;
    logic [3:0]     pstrb;
    logic [NS*DW-1:0] prdata;
    logic [NS-1:0]  pready, pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb4_multi_master_bridge #(
        .ADDR_WIDTH     (32),
        .DATA_WIDTH     (DW),
        .NUM_SLAVES     (NS),
        .SLAVE_ADDR_LSB (12),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .pclk      (pclk),
        .presetn   (presetn),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_strb  (req_strb),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .psel      (psel),
        .penable   (penable),
        .pwrite    (pwrite),
        .paddr     (paddr),
        .pwdata    (pwdata),
        .pstrb     (pstrb),
        .prdata    (prdata),
        .pready    (pready),
        .pslverr   (pslverr)
    );

    always #5 pclk = ~pclk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge pclk);
        #1;
    endtask

    // Non-selected slaves get random handshake/data so they must be ignored.
    task automatic drive_slaves(input logic [NS-1:0] sel_mask);
        pready  = 4'($urandom) & ~sel_mask;
        pslverr = 4'($urandom);
        for (int s = 0; s < NS; s++) prdata[s*DW +: DW] = $urandom;
    endtask

    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] strb, input int waits, input logic [31:0] sdata,
                           input bit serr, input int hold);
        logic [31:0] idx_full;
        int          idx;
        bit          hit, tmo;
        int          acc;
        logic [3:0]  exp_sel;
        logic [31:0] exp_rdata;
        bit          exp_err;

        // Transaction-level expectation.
        idx_full  = addr >> 12;
        hit       = (idx_full < NS);
        idx       = hit ? int'(idx_full) : 0;
        exp_sel   = hit ? 4'(1 << idx) : 4'b0000;
        tmo       = hit && TMO_EN && (waits >= TMO);
        acc       = tmo ? TMO : waits + 1;
        exp_err   = !hit || tmo || serr;
        exp_rdata = (!hit || tmo || serr || wr) ? 32'h0 : sdata;

        check_eq("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_strb  = strb;
        drive_slaves(4'b0000);
        step();
        req_valid = 1'b0;
        req_write = 1'($urandom);
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_strb  = 4'($urandom);

        if (hit) begin
            check_eq("setup_psel", psel, exp_sel);
            check_eq("setup_penable", penable, 1'b0);
            check_eq("setup_paddr", paddr, addr);
            check_eq("setup_pwrite", pwrite, wr);
            check_eq("setup_pwdata", pwdata, wdata);
            check_eq("setup_pstrb", pstrb, wr ? strb : 4'b0000);
            check_eq("setup_req_ready", req_ready, 1'b0);
            check_eq("setup_rsp_valid", rsp_valid, 1'b0);
            drive_slaves(exp_sel);
            step();
            for (int a = 1; a <= acc; a++) begin
                check_eq("access_psel", psel, exp_sel);
                check_eq("access_penable", penable, 1'b1);
                check_eq("access_paddr", paddr, addr);
                check_eq("access_rsp_valid", rsp_valid, 1'b0);
                drive_slaves(exp_sel);
                if (!tmo && (a == acc)) begin
                    pready[idx]            = 1'b1;
                    pslverr[idx]           = serr;
                    prdata[idx*DW +: DW]   = sdata;
                end else begin
                    pslverr[idx] = 1'($urandom);
                end
                step();
            end
            drive_slaves(4'b0000);
        end else begin
            check_eq("miss_psel", psel, 4'b0000);
        end

        check_eq("rsp_valid", rsp_valid, 1'b1);
        check_eq("rsp_err", rsp_err, exp_err);
        check_eq("rsp_rdata", rsp_rdata, exp_rdata);
        check_eq("rsp_psel_idle", psel, 4'b0000);
        check_eq("rsp_penable", penable, 1'b0);
        for (int h = 0; h < hold; h++) begin
            rsp_ready = 1'b0;
            step();
            check_eq("hold_rsp_valid", rsp_valid, 1'b1);
            check_eq("hold_rsp_rdata", rsp_rdata, exp_rdata);
            check_eq("hold_rsp_err", rsp_err, exp_err);
            check_eq("hold_req_ready", req_ready, 1'b0);
        end
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_eq("post_rsp_valid", rsp_valid, 1'b0);
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_psel"}, psel, 4'b0000);
        check_eq({tag, "_penable"}, penable, 1'b0);
        check_eq({tag, "_pwrite"}, pwrite, 1'b0);
        check_eq({tag, "_paddr"}, paddr, 32'h0);
        check_eq({tag, "_pwdata"}, pwdata, 32'h0);
        check_eq({tag, "_pstrb"}, pstrb, 4'b0000);
        check_eq({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        check_eq({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        check_eq({tag, "_rsp_err"}, rsp_err, 1'b0);
        check_eq({tag, "_req_ready"}, req_ready, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [19:0] ridx;
        logic [31:0] raddr;

        presetn   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_strb  = '0;
        rsp_ready = 1'b0;
        pready    = '0;
        pslverr   = '0;
        prdata    = '0;
        repeat (3) step();
        check_reset_values("reset");
        presetn = 1'b1;
        step();

        // Zero-wait write, waited read, slave error, decode miss.
        run_txn(1'b1, 32'h0000_1004, 32'hA5A5_0001, 4'b0011, 0, 32'h0, 1'b0, 0);
        run_txn(1'b0, 32'h0000_2010, 32'h1111_2222, 4'b1111, 3, 32'hDEAD_BEEF, 1'b0, 0);
        run_txn(1'b0, 32'h0000_0040, 32'h0, 4'b1111, 0, 32'h1234_5678, 1'b1, 1);
        run_txn(1'b1, 32'h0000_4000, 32'hCAFE_F00D, 4'b1111, 0, 32'h0, 1'b0, 0);
        // Long wait on slave 3: times out with the feature, else completes after 110 waits.
        run_txn(1'b0, 32'h0000_3008, 32'h0, 4'b0000, 110, 32'h0BAD_C0DE, 1'b0, 0);
        // Same-cycle pready at the timeout boundary still completes normally.
        run_txn(1'b0, 32'h0000_300C, 32'h0, 4'b0000, TMO - 1, 32'h5555_AAAA, 1'b0, 0);
        // Backpressure: response held for 5 cycles.
        run_txn(1'b0, 32'h0000_1020, 32'h0, 4'b0000, 1, 32'h7777_8888, 1'b0, 5);

        // Reset pulsed mid-ACCESS drops the command without a response.
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h0000_1000;
        req_wdata = 32'h1357_9BDF;
        req_strb  = 4'b1111;
        drive_slaves(4'b0000);
        step();
        req_valid = 1'b0;
        drive_slaves(4'b0010);
        step();
        check_eq("pre_reset_penable", penable, 1'b1);
        #2;
        presetn = 1'b0;
        #1;
        check_reset_values("midreset");
        step();
        presetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check_eq("post_reset_rsp_valid", rsp_valid, 1'b0);
            check_eq("post_reset_req_ready", req_ready, 1'b1);
            check_eq("post_reset_psel", psel, 4'b0000);
        end

        // Randomized traffic, mostly hits with occasional misses.
        for (int t = 0; t < 60; t++) begin
            ridx  = ($urandom_range(0, 9) == 0) ? 20'($urandom_range(4, 20'hFFFFF)) : 20'($urandom_range(0, 3));
            raddr = {ridx, 12'($urandom)};
            run_txn(1'($urandom), raddr, $urandom, 4'($urandom),
                    $urandom_range(0, 4), $urandom, ($urandom_range(0, 7) == 0),
                    $urandom_range(0, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/apb4_multi_master_bridge.md
# apb4_multi_master_bridge

Parametrised APB4 requester bridge. It converts a simple valid/ready command/response channel into APB4 transfers toward NUM_SLAVES peripherals, with one-hot PSEL address decoding, byte strobes, decode-error generation and an optional wait-state timeout. It sits between the register-manager command path and the per-peripheral APB4 slave ports, and supersedes single-slave, point-to-point APB wiring.

## Interface
- ADDR_WIDTH, 32, address width of req_addr and paddr.
- DATA_WIDTH, 32, data width; must be 8, 16 or 32.
- NUM_SLAVES, 4, number of APB slaves; range 1..16.
- SLAVE_ADDR_LSB, 12, lowest address bit of the slave index field.
- TIMEOUT_CYCLES, 16, ACCESS-phase cycles allowed before abort; only used with the timeout feature.
- pclk  in  1  APB clock; all logic is on its rising edge.
- presetn  in  1  reset, asynchronous, active-low.
- req_valid  in  1  command valid.
- req_ready  out  1  command accepted when high together with req_valid.
- req_write  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_WIDTH  byte address.
- req_wdata  in  DATA_WIDTH  write data.
- req_strb  in  DATA_WIDTH/8  byte strobes; ignored for reads.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data; 0 for writes and for errors.
- rsp_err  out  1  PSLVERR, decode miss or timeout.
- psel  out  NUM_SLAVES  one-hot slave select.
- penable  out  1  APB enable.
- pwrite  out  1  APB direction.
- paddr  out  ADDR_WIDTH  APB address.
- pwdata  out  DATA_WIDTH  APB write data.
- pstrb  out  DATA_WIDTH/8  APB strobes; 0 on reads.
- prdata  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i uses slice i.
- pready  in  NUM_SLAVES  per-slave ready.
- pslverr  in  NUM_SLAVES  per-slave error.

## Operation
- FSM states are IDLE, SETUP, ACCESS and RESP.
- **IDLE**
  - req_ready is 1.
  - On req_valid, latch write, addr, wdata and strb.
  - Decode idx = req_addr[ADDR_WIDTH-1:SLAVE_ADDR_LSB].
  - If idx < NUM_SLAVES, go to SETUP. Otherwise go to RESP with rsp_err=1, rsp_rdata=0, and no APB activity.
- **SETUP**
  - psel[idx]=1, penable=0.
  - paddr, pwrite, pwdata and pstrb are driven from the latched values.
  - Always go to ACCESS.
- **ACCESS**
  - psel[idx]=1, penable=1, with all address, control and data outputs held stable.
  - On pready[idx]=1, capture prdata slice idx (reads only) and pslverr[idx] into rsp_err, then go to RESP.
  - psel and penable are 0 in the following cycle.
- **RESP**
  - rsp_valid=1; rsp_rdata and rsp_err are held stable until rsp_ready=1.
  - When rsp_ready=1, go to IDLE.
- There are no back-to-back APB transfers; each command passes through IDLE.
- pready, prdata and pslverr of non-selected slaves are ignored.
- Reset asserted mid-operation:
  - All outputs go immediately to their reset values and the FSM goes to IDLE.
  - The in-flight command is dropped and no response is issued.
- Reset values:
  - psel, penable, pwrite, paddr, pwdata, pstrb, rsp_valid, rsp_rdata and rsp_err are 0.
  - req_ready is 1.

## Timing
- The command is accepted at edge 0.
- SETUP occupies cycle 1 and ACCESS begins in cycle 2.
- With zero wait states, rsp_valid rises in cycle 3. Each wait state adds one cycle.
- On a decode miss, rsp_valid rises in cycle 1.
- Minimum command-to-command spacing is 4 cycles with zero wait states and rsp_ready held high.
- All outputs are registered or decoded only from state; there is no combinational path from input to output.

## Configuration
- Macro: APB4_BRIDGE_TIMEOUT_EN.
- **Defined:**
  - An 8-bit-or-wider counter clears on entry to ACCESS and increments in each ACCESS cycle where pready[idx]=0.
  - When the count reaches TIMEOUT_CYCLES, the transfer aborts: psel and penable drop next cycle, the FSM goes to RESP, rsp_err=1 and rsp_rdata=0.
  - If pready arrives on the same cycle the count reaches TIMEOUT_CYCLES, the normal pready completion takes priority.
- **Undefined:** the counter is absent and ACCESS waits indefinitely for pready.

## Structure
- Package apb4_bridge_pkg holds:
  - the state enum apb4_bridge_state_e (IDLE, SETUP, ACCESS, RESP);
  - the packed struct apb4_bridge_req_t (write, addr, wdata, strb);
  - the packed struct apb4_bridge_rsp_t (rdata, err).
- Sub-module apb4_addr_decoder is combinational. It takes addr and produces a one-hot select of NUM_SLAVES bits plus a hit flag, parametrised by NUM_SLAVES and SLAVE_ADDR_LSB.

## Test plan
All scenarios use NUM_SLAVES=4 and SLAVE_ADDR_LSB=12.
- **Zero-wait write:** write to 0x0000_1004, wdata 0xA5A5_0001, strb 4'b0011.
  - psel=4'b0010 in cycle 1, penable=1 in cycle 2, pstrb=4'b0011.
  - rsp_valid in cycle 3 with rsp_err=0 and rsp_rdata=0.
- **Waited read:** read 0x0000_2010; slave 2 returns pready after 3 wait cycles with prdata 0xDEAD_BEEF.
  - rsp_rdata=0xDEAD_BEEF in cycle 6; paddr stays stable throughout ACCESS.
- **Slave error:** read from slave 0 with pslverr[0]=1 together with pready.
  - rsp_err=1 and the FSM returns to IDLE after rsp_ready.
- **Decode miss:** access to 0x0000_4000.
  - psel stays 0, rsp_valid in cycle 1, rsp_err=1, rsp_rdata=0.
- **Timeout (macro defined, TIMEOUT_CYCLES=16):** pready[3] held at 0.
  - psel drops after 16 ACCESS cycles, rsp_err=1.
  - Without the macro, psel stays high for more than 100 cycles.
- **Backpressure and reset:**
  - rsp_ready held 0 for 5 cycles: the response stays stable and req_ready stays 0.
  - presetn pulsed low during ACCESS: psel and penable go to 0 immediately, no rsp_valid is issued, and req_ready=1 after release.
